// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry output register with register-file read-address steering,
// writeback bypass for the one-cycle non-bypassing register file, and x0 forcing.
module decode_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  localparam int AW           = $clog2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  flush,
  output logic [AW-1:0]         rf_rd0,
  output logic [AW-1:0]         rf_rd1,
  input  logic [DATA_WIDTH-1:0] rf_data0,
  input  logic [DATA_WIDTH-1:0] rf_data1,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_rs1_val,
  output logic [DATA_WIDTH-1:0] out_rs2_val,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [AW-1:0]         out_rd,
  output logic                  out_rd_we,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic                  out_funct7b5,
  output logic                  out_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic                  accept;
  logic [AW-1:0]         rs1_q;
  logic [AW-1:0]         rs2_q;
  logic                  byp_hit0;
  logic                  byp_hit1;
  logic [DATA_WIDTH-1:0] byp_data0;
  logic [DATA_WIDTH-1:0] byp_data1;
  logic [31:0]           imm32;
  logic                  legal;
  logic                  writes;
  logic                  rd_we_d;

  // valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds valid and its payload stable until that edge.
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign rf_rd0 = accept ? AW'(in_instr[19:15]) : rs1_q;
  assign rf_rd1 = accept ? AW'(in_instr[24:20]) : rs2_q;

  always_comb begin
    imm32  = '0;
    legal  = 1'b1;
    writes = 1'b0;
    case (in_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        imm32  = {in_instr[31:12], 12'b0};
        writes = 1'b1;
      end
      OP_JAL: begin
        imm32  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        writes = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
        writes = 1'b1;
      end
      OP_SYSTEM: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      OP_STORE:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      OP_BRANCH: imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      OP_OP:     writes = 1'b1;
      OP_FENCE:  writes = 1'b0;
      default:   legal = 1'b0;
    endcase
    if (in_instr[1:0] != 2'b11) legal = 1'b0;
    if (!legal) begin
      imm32  = '0;
      writes = 1'b0;
    end
  end

  assign rd_we_d = writes && (in_instr[11:7] != 5'd0);

  // Operands: x0 is forced to zero; a writeback that landed on the edge the address was
  // presented is newer than what the register file returns, so it wins.
  assign out_rs1_val = (rs1_q == '0) ? '0 : (byp_hit0 ? byp_data0 : rf_data0);
  assign out_rs2_val = (rs2_q == '0) ? '0 : (byp_hit1 ? byp_data1 : rf_data1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_rd_we    <= 1'b0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      byp_hit0     <= 1'b0;
      byp_hit1     <= 1'b0;
      byp_data0    <= '0;
      byp_data1    <= '0;
    end else begin
      byp_hit0  <= wb_valid && (wb_rd == rf_rd0) && (rf_rd0 != '0);
      byp_hit1  <= wb_valid && (wb_rd == rf_rd1) && (rf_rd1 != '0);
      byp_data0 <= wb_data;
      byp_data1 <= wb_data;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_imm      <= DATA_WIDTH'($signed(imm32));
        out_rd       <= rd_we_d ? AW'(in_instr[11:7]) : '0;
        out_rd_we    <= rd_we_d;
        out_opcode   <= in_instr[6:0];
        out_funct3   <= in_instr[14:12];
        out_funct7b5 <= in_instr[30];
        out_illegal  <= !legal;
        rs1_q        <= AW'(in_instr[19:15]);
        rs2_q        <= AW'(in_instr[24:20]);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a naive register file environment plus a field-level decode model
// driven by directed and randomized instruction streams.
module tb_decode_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_instr = '0;
  logic [DW-1:0] in_pc = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] rf_rd0, rf_rd1;
  logic [DW-1:0] rf_data0 = '0;
  logic [DW-1:0] rf_data1 = '0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [AW-1:0] out_rd;
  logic          out_rd_we;
  logic [6:0]    out_opcode;
  logic [2:0]    out_funct3;
  logic          out_funct7b5;
  logic          out_illegal;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  typedef struct packed {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;
  } dec_t;

  always #5 clk = ~clk;

  decode_stage #(.DATA_WIDTH(DW), .NUM_REGISTERS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .rf_rd0(rf_rd0), .rf_rd1(rf_rd1), .rf_data0(rf_data0), .rf_data1(rf_data1),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  // Register file without internal bypass; it even lets x0 be written, so only the
  // stage can keep x0 reads at zero.
  logic [31:0] regs [32] = '{default: 32'h0};
  always @(posedge clk) begin
    rf_data0 <= regs[rf_rd0];
    rf_data1 <= regs[rf_rd1];
    if (wb_valid) regs[wb_rd] <= wb_data;
  end

  function automatic int sx(input int v, input int n);
    return (v >= (1 << (n - 1))) ? v - (1 << n) : v;
  endfunction

  // Expected outputs for an instruction: operands are the newest architectural values.
  function automatic dec_t model(input logic [31:0] w, input logic [31:0] pc);
    dec_t d;
    int imm = 0;
    bit legal = 1'b1;
    bit wr = 1'b0;
    case (w[6:0])
      7'b0110111, 7'b0010111: begin imm = int'({w[31:12], 12'h000}); wr = 1'b1; end
      7'b1101111: begin imm = sx(int'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21); wr = 1'b1; end
      7'b1100111, 7'b0000011, 7'b0010011: begin imm = sx(int'(w[31:20]), 12); wr = 1'b1; end
      7'b1110011: imm = sx(int'(w[31:20]), 12);
      7'b0100011: imm = sx(int'({w[31:25], w[11:7]}), 12);
      7'b1100011: imm = sx(int'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      7'b0110011: wr = 1'b1;
      7'b0001111: wr = 1'b0;
      default: legal = 1'b0;
    endcase
    if (w[1:0] != 2'b11) legal = 1'b0;
    if (!legal) begin imm = 0; wr = 1'b0; end
    d.pc       = pc;
    d.rs1      = (w[19:15] == 5'd0) ? 32'h0 : regs[w[19:15]];
    d.rs2      = (w[24:20] == 5'd0) ? 32'h0 : regs[w[24:20]];
    d.imm      = 32'(imm);
    d.rd_we    = wr && (w[11:7] != 5'd0);
    d.rd       = d.rd_we ? w[11:7] : 5'd0;
    d.opcode   = w[6:0];
    d.funct3   = w[14:12];
    d.funct7b5 = w[30];
    d.illegal  = !legal;
    return d;
  endfunction

  function automatic dec_t obs();
    dec_t d;
    d.pc = out_pc; d.rs1 = out_rs1_val; d.rs2 = out_rs2_val; d.imm = out_imm;
    d.rd = out_rd; d.rd_we = out_rd_we; d.opcode = out_opcode; d.funct3 = out_funct3;
    d.funct7b5 = out_funct7b5; d.illegal = out_illegal;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr(input bit legal);
    logic [6:0] ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                             7'b1110011};
    logic [31:0] w = $urandom();
    if (legal) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    wb_valid = 1'b1; wb_rd = r; wb_data = v;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_handshake got valid/ready=%b exp=01", {out_valid, in_ready});
    end
    total++;
    if (obs() !== dec_t'(0) || rf_rd0 !== 5'd0 || rf_rd1 !== 5'd0) begin
      bad++; $display("FAIL reset_outputs got=%h rd0=%0d rd1=%0d exp all zero", obs(), rf_rd0, rf_rd1);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    dec_t e, o;
    write_reg(5'd5, 32'h1234);
    in_valid = 1'b1; in_instr = 32'hFFF28093; in_pc = 32'h100; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || rf_rd0 !== 5'd5) begin
      bad++; $display("FAIL addi_accept_addr got ready=%b rd0=%0d exp ready=1 rd0=5", in_ready, rf_rd0);
    end
    tick();
    in_valid = 1'b0;
    e = model(32'hFFF28093, 32'h100); o = obs();
    total++;
    if (out_valid !== 1'b1 || o !== e) begin
      bad++; $display("FAIL addi_decode got v=%b %h exp v=1 %h", out_valid, o, e);
    end
    total++;
    if ({out_rs1_val, out_imm, out_rd, out_rd_we} !== {32'h1234, 32'hFFFFFFFF, 5'd1, 1'b1}) begin
      bad++; $display("FAIL addi_fields got rs1=%h imm=%h rd=%0d we=%b exp 1234 ffffffff 1 1",
                      out_rs1_val, out_imm, out_rd, out_rd_we);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL addi_drain got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_bypass();
    dec_t e, o;
    write_reg(5'd1, 32'h11111111);
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h104;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hA5A5A5A5;
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    e = model(32'h002081B3, 32'h104); o = obs();
    total++;
    if (out_rs1_val !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL bypass_rs1 got=%h exp=a5a5a5a5", out_rs1_val);
    end
    total++;
    if (o !== e) begin
      bad++; $display("FAIL bypass_decode got=%h exp=%h", o, e);
    end
    tick();
  endtask

  task automatic test_stall();
    dec_t e, o;
    write_reg(5'd7, 32'h77);
    in_valid = 1'b1; in_instr = 32'h00712423; in_pc = 32'h200; out_ready = 1'b0;
    tick();
    in_instr = 32'h00000013; in_pc = 32'h204;
    for (int c = 1; c <= 3; c++) begin
      #1;
      e = model(32'h00712423, 32'h200); o = obs();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || o !== e) begin
        bad++; $display("FAIL stall_cycle%0d got rdy=%b v=%b %h exp rdy=0 v=1 %h",
                        c, in_ready, out_valid, o, e);
      end
      if (c == 2) begin
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
      end
      if (c == 3) begin
        total++;
        if ({out_rs2_val, out_imm, out_rd_we, out_rd} !== {32'h55, 32'h8, 1'b0, 5'd0}) begin
          bad++; $display("FAIL stall_sw_fields got rs2=%h imm=%h we=%b rd=%0d exp 55 8 0 0",
                          out_rs2_val, out_imm, out_rd_we, out_rd);
        end
        in_valid = 1'b0; out_ready = 1'b1;
      end
      tick();
      wb_valid = 1'b0;
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_drain got out_valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_imm_x0();
    dec_t e, o;
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h300;
    tick();
    in_instr = 32'h12345237; in_pc = 32'h304;
    e = model(32'hFE000EE3, 32'h300); o = obs();
    total++;
    if (out_imm !== 32'hFFFFFFFC || o !== e) begin
      bad++; $display("FAIL beq_imm got imm=%h %h exp imm=fffffffc %h", out_imm, o, e);
    end
    tick();
    in_valid = 1'b0;
    e = model(32'h12345237, 32'h304); o = obs();
    total++;
    if ({out_imm, out_rd, out_rd_we} !== {32'h12345000, 5'd4, 1'b1} || o !== e) begin
      bad++; $display("FAIL lui_imm got imm=%h rd=%0d we=%b exp 12345000 4 1", out_imm, out_rd, out_rd_we);
    end
    tick();
    in_valid = 1'b1; in_instr = 32'h00000333; in_pc = 32'h308; out_ready = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if ({out_rs1_val, out_rs2_val, out_rd, out_rd_we} !== {64'h0, 5'd6, 1'b1}) begin
        bad++; $display("FAIL x0_read%0d got rs1=%h rs2=%h rd=%0d we=%b exp 0 0 6 1",
                        c, out_rs1_val, out_rs2_val, out_rd, out_rd_we);
      end
      tick();
    end
    wb_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    dec_t e, o;
    logic [63:0] item;
    logic [31:0] w;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = rand_instr(1'b1);
      in_valid = 1'b1; in_instr = w; in_pc = 32'h1000 + 32'(k * 4);
      exp_q.push_back({w, in_pc});
      wb_valid = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 31)); wb_data = $urandom();
      tick();
      item = exp_q.pop_front();
      e = model(item[63:32], item[31:0]); o = obs();
      total++;
      if (out_valid !== 1'b1 || o !== e) begin
        bad++; $display("FAIL b2b_item%0d got v=%b %h exp v=1 %h", k, out_valid, o, e);
      end
    end
    idle();
    tick();
    total++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_end got out_valid=%b left=%0d exp 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_illegal();
    dec_t e, o;
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      w = $urandom();
      w[6:0] = (k == 0) ? 7'h7F : 7'b0000010;
      in_valid = 1'b1; in_instr = w; in_pc = 32'h400; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      e = model(w, 32'h400); o = obs();
      total++;
      if ({out_illegal, out_rd_we, out_rd, out_imm} !== {1'b1, 1'b0, 5'd0, 32'h0} || o !== e) begin
        bad++; $display("FAIL illegal%0d got ill=%b we=%b imm=%h %h exp ill=1 we=0 imm=0 %h",
                        k, out_illegal, out_rd_we, out_imm, o, e);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_instr = rand_instr(1'b1); in_pc = 32'h500; out_ready = 1'b1;
    tick();
    in_instr = rand_instr(1'b1); in_pc = 32'h504; flush = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL flush_cycle got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear got out_valid=%b exp 0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_no_accept got out_valid=%b exp 0", out_valid);
    end
    in_valid = 1'b1; in_instr = rand_instr(1'b1); in_pc = 32'h508; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_stalled got out_valid=%b exp 0", out_valid);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; in_instr = rand_instr(1'b1); in_pc = 32'h600; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01 || obs() !== dec_t'(0) || rf_rd0 !== 5'd0 || rf_rd1 !== 5'd0) begin
      bad++; $display("FAIL reset_mid_stall got v=%b rdy=%b %h rd0=%0d rd1=%0d exp 0 1 zeros",
                      out_valid, in_ready, obs(), rf_rd0, rf_rd1);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_random();
    bit mv = 1'b0;
    bit exp_rdy, acc;
    logic [31:0] held_w = '0;
    logic [31:0] held_pc = '0;
    logic [31:0] w;
    logic [4:0] exp_addr;
    dec_t e, o;
    for (int c = 0; c < 300; c++) begin
      w = rand_instr($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 3) != 0); in_instr = w; in_pc = $urandom();
      out_ready = ($urandom_range(0, 2) != 0); flush = ($urandom_range(0, 15) == 0);
      wb_valid = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 31)); wb_data = $urandom();
      #1;
      exp_rdy = (!mv || out_ready) && !flush;
      acc = in_valid && exp_rdy;
      total++;
      if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy);
      end
      if (acc || mv) begin
        exp_addr = acc ? w[19:15] : held_w[19:15];
        total++;
        if (rf_rd0 !== exp_addr) begin
          bad++; $display("FAIL rand_addr c=%0d got=%0d exp=%0d", c, rf_rd0, exp_addr);
        end
      end
      tick();
      if (flush) mv = 1'b0;
      else if (acc) begin mv = 1'b1; held_w = w; held_pc = in_pc; end
      else if (out_ready) mv = 1'b0;
      total++;
      if (out_valid !== mv) begin
        bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, mv);
      end
      if (mv) begin
        e = model(held_w, held_pc); o = obs();
        total++;
        if (o !== e) begin
          bad++; $display("FAIL rand_decode c=%0d got=%h exp=%h", c, o, e);
        end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_stall();
    test_imm_x0();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the RV32I pipeline, between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake and drives the register file read addresses at the acceptance edge. It decodes fields and immediates into a single-entry output register. Because register file reads are one-cycle and the register file does not bypass, this stage also forwards same-edge writeback data, forces x0 reads to zero, and re-reads the held source registers while stalled.

## Interface
- DATA_WIDTH, 32, operand/immediate width; must be >= 32.
- NUM_REGISTERS, 32, architectural register count; address width is AW = $clog2(NUM_REGISTERS).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; high when (!out_valid || out_ready) && !flush.
- in_instr  in  32  instruction word.
- in_pc  in  DATA_WIDTH  instruction address.
- flush  in  1  discard the held instruction; has priority over all other events.
- rf_rd0 / rf_rd1  out  AW  register file read addresses (rs1 / rs2).
- rf_data0 / rf_data1  in  DATA_WIDTH  register file read data, one cycle after address.
- wb_valid  in  1  writeback writes this cycle (the same signal as the register file write enable).
- wb_rd  in  AW  writeback destination.
- wb_data  in  DATA_WIDTH  writeback data.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute accepts.
- out_pc  out  DATA_WIDTH  pc of the held instruction.
- out_rs1_val / out_rs2_val  out  DATA_WIDTH  source operands after the x0/bypass mux.
- out_imm  out  DATA_WIDTH  sign-extended immediate; 0 for R-type.
- out_rd  out  AW  destination register; 0 when out_rd_we = 0.
- out_rd_we  out  1  instruction writes rd, and rd != 0.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7b5  out  1  instr[30].
- out_illegal  out  1  opcode is unsupported, or instr[1:0] != 2'b11.

## Operation
- Accept when in_valid && in_ready. At the accepting edge, capture pc, the decoded fields, rs1 (instr[19:15]) and rs2 (instr[24:20]) into the stage registers, and set out_valid.
- Address mux: when accepting, rf_rd0/rf_rd1 come combinationally from in_instr. Otherwise they come from the held rs1/rs2, so the register file re-reads every cycle while the stage holds an instruction.
- Bypass capture: at every edge, per port, byp_hit <= wb_valid && wb_rd == A && A != 0, and byp_data <= wb_data. Here A is the address driven on that edge.
- Operand output: if the held rs is 0, output 0. Else if byp_hit, output byp_data. Else output rf_data. This mux is combinational from the registered state and rf_data.
- Immediates:
  - I-type: LOAD, OP-IMM, JALR, SYSTEM.
  - S-type: STORE.
  - B-type: BRANCH; bit 0 is 0.
  - U-type: LUI, AUIPC; low 12 bits are 0.
  - J-type: JAL; bit 0 is 0.
  - All immediates sign-extend from instr[31] to DATA_WIDTH.
- Supported opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. Any other opcode sets out_illegal = 1, out_rd_we = 0 and out_imm = 0.
- out_rd_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP when rd != 0.
- Transfer to execute occurs on out_valid && out_ready. If no new instruction is accepted on that edge, out_valid clears.
- Flush: at the edge, out_valid <= 0. in_ready is 0 during the flush cycle, so no instruction enters that cycle.

## Timing
- Latency is one cycle: an instruction accepted at edge E0 drives out_valid and valid operands in the cycle after E0.
- Throughput is one instruction per cycle when out_ready stays high.
- Stall: outputs other than the operands hold stable. Operands may change only because a writeback to a held rs lands during the stall; the re-read plus bypass yields the newest value one cycle later.
- Writeback on the same edge as acceptance, to the same rs: out_rs*_val equals wb_data in the next cycle (bypass).
- Writeback to rs 0: ignored, and the operand stays 0.
- Reset (any time, including mid-stall):
  - out_valid = 0, in_ready = 1.
  - All out_* = 0 and rf_rd0/rf_rd1 = held value 0.
  - byp_hit = 0.
- Simultaneous flush and out_ready: flush wins and nothing is accepted. The transfer is still seen by execute in that cycle, because out_valid was high.

## Test plan
- Reset → out_valid = 0, in_ready = 1, all outputs 0. Write x5 = 0x1234 through the register file, then accept `addi x1,x5,-1` (0xFFF28093) → next cycle out_rs1_val = 0x1234, out_imm = 0xFFFFFFFF, out_rd = 1, out_rd_we = 1.
- Accept `add x3,x1,x2` with wb_valid, wb_rd = 1, wb_data = 0xA5A5A5A5 on the same edge → out_rs1_val = 0xA5A5A5A5, not the stale register file value.
- Hold out_ready = 0 for 3 cycles with `sw x7,8(x2)` held, and write x7 = 0x55 in the 2nd cycle → in_ready = 0 throughout; out_rs2_val = 0x55 from the 3rd cycle; out_imm = 8, out_rd_we = 0.
- `beq` with offset -4 (0xFE000EE3) → out_imm = 0xFFFFFFFC. `lui x4,0x12345` → out_imm = 0x12345000. Any read of x0 → 0, even after wb_rd = 0 with data 0xFF.
- Back-to-back stream of 8 instructions with out_ready = 1 → 8 outputs on 8 consecutive cycles, in order. Opcode 0x7F → out_illegal = 1. Assert flush mid-stream → out_valid = 0 the next cycle, and the flush-cycle input is not accepted.
